// File: rtl/alu_ctrl_pipe_if.sv
// Handshake bundle between ID-stage control, the ALU control decoder and the EX-stage ALU.
// master = upstream/EX side driving requests and OutReady; slave = the decoder itself.
interface alu_ctrl_pipe_if #(
    parameter int unsigned OP_W = 6
);
    logic            InValid;
    logic            InReady;
    logic [31:0]     Instr;
    logic [1:0]      ALUOp;
    logic            OutValid;
    logic            OutReady;
    logic [OP_W-1:0] ALUCtl;
    logic            OutMulti;
    logic            Illegal;
    logic            HiLoWe;
    logic            Busy;

    modport master (
        output InValid,
        output Instr,
        output ALUOp,
        output OutReady,
        input  InReady,
        input  OutValid,
        input  ALUCtl,
        input  OutMulti,
        input  Illegal,
        input  HiLoWe,
        input  Busy
    );

    modport slave (
        input  InValid,
        input  Instr,
        input  ALUOp,
        input  OutReady,
        output InReady,
        output OutValid,
        output ALUCtl,
        output OutMulti,
        output Illegal,
        output HiLoWe,
        output Busy
    );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control decoder with a stall FSM for multi-cycle HI/LO ops.
// Optional feature: define ALUCTL_ROTATE_EN to decode srl/srlv with the R bit as ROTR.
module alu_ctrl_pipe #(
    parameter int unsigned OP_W       = 6,
    parameter int unsigned MUL_CYCLES = 4
) (
    input logic           Clk,
    input logic           Reset,
    alu_ctrl_pipe_if.slave bus
);

    localparam int unsigned CntW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [5:0] CodeAdd  = 6'd0;
    localparam logic [5:0] CodeSub  = 6'd1;
    localparam logic [5:0] CodeMul  = 6'd2;
    localparam logic [5:0] CodeAnd  = 6'd3;
    localparam logic [5:0] CodeOr   = 6'd4;
    localparam logic [5:0] CodeSlt  = 6'd5;
    localparam logic [5:0] CodeSll  = 6'd8;
    localparam logic [5:0] CodeSrl  = 6'd9;
    localparam logic [5:0] CodeMadd = 6'd11;
    localparam logic [5:0] CodeMsub = 6'd12;
    localparam logic [5:0] CodeXor  = 6'd13;
    localparam logic [5:0] CodeNor  = 6'd14;
    localparam logic [5:0] CodeRotr = 6'd17;
    localparam logic [5:0] CodeSra  = 6'd35;
    localparam logic [5:0] CodeSltu = 6'd50;
    localparam logic [5:0] CodeIll  = 6'd63;

    localparam logic [5:0] OpSpecial  = 6'b000000;
    localparam logic [5:0] OpSpecial2 = 6'b011100;

    if (OP_W < 6) begin : gen_opw_chk
        $error("OP_W must be at least 6");
    end
    if (MUL_CYCLES < 2) begin : gen_mul_chk
        $error("MUL_CYCLES must be at least 2");
    end

    typedef enum logic {
        StRun,
        StMwait
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic            out_valid_q, out_valid_d;
    logic [OP_W-1:0] alu_ctl_q, alu_ctl_d;
    logic            out_multi_q, out_multi_d;
    logic            illegal_q, illegal_d;

    logic            in_ready;
    logic            hi_lo_we;
    logic            busy;

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic            rot_srl;
    logic            rot_srlv;
    logic [5:0]      dec_code;
    logic            dec_multi;
    logic            dec_illegal;
    logic [OP_W-1:0] dec_ctl_w;

    // Most instruction fields (rs/rt/rd/imm) are irrelevant to ALU control.
    logic unused_instr;
    assign unused_instr = ^bus.Instr;

    assign opcode = bus.Instr[31:26];
    assign funct  = bus.Instr[5:0];

`ifdef ALUCTL_ROTATE_EN
    assign rot_srl  = bus.Instr[21];
    assign rot_srlv = bus.Instr[6];
`else
    assign rot_srl  = 1'b0;
    assign rot_srlv = 1'b0;
`endif

    always_comb begin
        dec_code  = CodeIll;
        dec_multi = 1'b0;
        case (bus.ALUOp)
            2'b00: dec_code = CodeAdd;
            2'b01: dec_code = CodeSub;
            2'b10: begin
                if (opcode == OpSpecial) begin
                    case (funct)
                        6'b100000, 6'b100001: dec_code = CodeAdd;
                        6'b100010, 6'b100011: dec_code = CodeSub;
                        6'b100100:            dec_code = CodeAnd;
                        6'b100101:            dec_code = CodeOr;
                        6'b100110:            dec_code = CodeXor;
                        6'b100111:            dec_code = CodeNor;
                        6'b101010:            dec_code = CodeSlt;
                        6'b101011:            dec_code = CodeSltu;
                        6'b000000, 6'b000100: dec_code = CodeSll;
                        6'b000010:            dec_code = rot_srl ? CodeRotr : CodeSrl;
                        6'b000110:            dec_code = rot_srlv ? CodeRotr : CodeSrl;
                        6'b000011, 6'b000111: dec_code = CodeSra;
                        6'b011000, 6'b011001: begin
                            dec_code  = CodeMul;
                            dec_multi = 1'b1;
                        end
                        default:              dec_code = CodeIll;
                    endcase
                end else if (opcode == OpSpecial2) begin
                    case (funct)
                        6'b000010: dec_code = CodeMul;
                        6'b000000: begin
                            dec_code  = CodeMadd;
                            dec_multi = 1'b1;
                        end
                        6'b000100: begin
                            dec_code  = CodeMsub;
                            dec_multi = 1'b1;
                        end
                        default:   dec_code = CodeIll;
                    endcase
                end
            end
            default: begin
                case (opcode)
                    6'b001000, 6'b001001: dec_code = CodeAdd;
                    6'b001100:            dec_code = CodeAnd;
                    6'b001101:            dec_code = CodeOr;
                    6'b001110:            dec_code = CodeXor;
                    6'b001010:            dec_code = CodeSlt;
                    6'b001011:            dec_code = CodeSltu;
                    default:              dec_code = CodeIll;
                endcase
            end
        endcase
        dec_illegal = (dec_code == CodeIll);
    end

    always_comb begin
        dec_ctl_w      = '0;
        dec_ctl_w[5:0] = dec_code;
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        alu_ctl_d   = alu_ctl_q;
        out_multi_d = out_multi_q;
        illegal_d   = illegal_q;
        in_ready    = 1'b0;
        hi_lo_we    = 1'b0;
        busy        = 1'b0;

        case (state_q)
            StRun: begin
                // A pending multi op blocks intake: its handoff cycle moves us to MWAIT.
                in_ready = !out_valid_q || (bus.OutReady && !out_multi_q);
                if (out_valid_q && bus.OutReady) begin
                    out_valid_d = 1'b0;
                    if (out_multi_q) begin
                        state_d = StMwait;
                        count_d = CntW'(MUL_CYCLES - 1);
                    end
                end
                if (bus.InValid && in_ready) begin
                    out_valid_d = 1'b1;
                    alu_ctl_d   = dec_ctl_w;
                    out_multi_d = dec_multi;
                    illegal_d   = dec_illegal;
                end
            end
            StMwait: begin
                busy    = 1'b1;
                count_d = count_q - CntW'(1);
                if (count_q == CntW'(1)) begin
                    hi_lo_we = 1'b1;
                    state_d  = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StRun;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            alu_ctl_q   <= '0;
            out_multi_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            alu_ctl_q   <= alu_ctl_d;
            out_multi_q <= out_multi_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.InReady  = in_ready;
    assign bus.OutValid = out_valid_q;
    assign bus.ALUCtl   = alu_ctl_q;
    assign bus.OutMulti = out_multi_q;
    assign bus.Illegal  = illegal_q;
    assign bus.HiLoWe   = hi_lo_we;
    assign bus.Busy     = busy;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Bench for alu_ctrl_pipe: vector table through a scoreboard plus stall/multi/reset sequences.
module tb_alu_ctrl_pipe;

    localparam int unsigned OpW       = 6;
    localparam int unsigned MulCycles = 4;
`ifdef ALUCTL_ROTATE_EN
    localparam int RotCtl = 17;
`else
    localparam int RotCtl = 9;
`endif

    typedef struct {
        logic [1:0]  aluop;
        logic [31:0] instr;
        int          ctl;
        int          multi;
        int          ill;
    } vec_t;

    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;
    vec_t cur_exp;
    vec_t mon_e;
    vec_t sb[$];
    vec_t vecs[$];
    int   w;

    alu_ctrl_pipe_if #(.OP_W(OpW)) bus ();

    alu_ctrl_pipe #(
        .OP_W      (OpW),
        .MUL_CYCLES(MulCycles)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] a, input logic [5:0] op, input logic [5:0] fn,
                                input logic [31:0] extra, input int ctl, input int multi);
        vec_t v;
        v.aluop = a;
        v.instr = {op, 20'h0, fn} | extra;
        v.ctl   = ctl;
        v.multi = multi;
        v.ill   = (ctl == 63) ? 1 : 0;
        return v;
    endfunction

    // Scoreboard: push the expected record on accept, pop on output handshake.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (bus.OutValid && bus.OutReady) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("sb_ctl", int'(bus.ALUCtl), mon_e.ctl);
                    check("sb_multi", int'(bus.OutMulti), mon_e.multi);
                    check("sb_illegal", int'(bus.Illegal), mon_e.ill);
                end
            end
            if (bus.InValid && bus.InReady) sb.push_back(cur_exp);
        end
    end

    task automatic send(input vec_t v, output int waited);
        bit ok;
        ok          = 1'b0;
        waited      = 0;
        bus.InValid = 1'b1;
        bus.ALUOp   = v.aluop;
        bus.Instr   = v.instr;
        cur_exp     = v;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge Clk);
            ok = bus.InReady;
            @(posedge Clk);
            #1;
            if (!ok) waited++;
        end
        if (!ok) check("send_timeout", 0, 1);
        bus.InValid = 1'b0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset        = 1'b1;
        bus.InValid  = 1'b0;
        bus.ALUOp    = 2'b00;
        bus.Instr    = 32'h0;
        bus.OutReady = 1'b1;

        vecs.push_back(mk(2'b10, 6'b000000, 6'b100000, 32'h0, 0, 0));
        vecs.push_back(mk(2'b10, 6'b000000, 6'b100010, 32'h0, 1, 0));
        vecs.push_back(mk(2'b10, 6'b000000, 6'b100101, 32'h0, 4, 0));
        vecs.push_back(mk(2'b10, 6'b000000, 6'b101010, 32'h0, 5, 0));
        vecs.push_back(mk(2'b00, 6'b111111, 6'b111111, 32'hFFFF_FFFF, 0, 0));
        vecs.push_back(mk(2'b01, 6'b000100, 6'b011000, 32'h1234_5678, 1, 0));
        vecs.push_back(mk(2'b10, 6'b000000, 6'b100001, 32'h0, 0, 0));
        vecs.push_back(mk(2'b10, 6'b000000, 6'b100011, 32'h0, 1, 0));
        vecs.push_back(mk(2'b10, 6'b000000, 6'b100110, 32'h0, 13, 0));
        vecs.push_back(mk(2'b10, 6'b000000, 6'b100111, 32'h0, 14, 0));
        vecs.push_back(mk(2'b10, 6'b000000, 6'b101011, 32'h0, 50, 0));
        vecs.push_back(mk(2'b10, 6'b000000, 6'b000000, 32'h0, 8, 0));
        vecs.push_back(mk(2'b10, 6'b000000, 6'b000100, 32'h0, 8, 0));
        vecs.push_back(mk(2'b10, 6'b000000, 6'b000010, 32'h0, 9, 0));
        vecs.push_back(mk(2'b10, 6'b000000, 6'b000110, 32'h0, 9, 0));
        vecs.push_back(mk(2'b10, 6'b000000, 6'b000011, 32'h0, 35, 0));
        vecs.push_back(mk(2'b10, 6'b000000, 6'b000111, 32'h0, 35, 0));
        vecs.push_back(mk(2'b10, 6'b000000, 6'b000010, 32'h0020_0000, RotCtl, 0));
        vecs.push_back(mk(2'b10, 6'b000000, 6'b000110, 32'h0000_0040, RotCtl, 0));
        vecs.push_back(mk(2'b10, 6'b000000, 6'b011000, 32'h0, 2, 1));
        vecs.push_back(mk(2'b10, 6'b011100, 6'b000010, 32'h0, 2, 0));
        vecs.push_back(mk(2'b10, 6'b000000, 6'b011001, 32'h0, 2, 1));
        vecs.push_back(mk(2'b10, 6'b011100, 6'b000000, 32'h0, 11, 1));
        vecs.push_back(mk(2'b10, 6'b011100, 6'b000100, 32'h0, 12, 1));
        vecs.push_back(mk(2'b11, 6'b001000, 6'b000000, 32'h0, 0, 0));
        vecs.push_back(mk(2'b11, 6'b001001, 6'b000000, 32'h0, 0, 0));
        vecs.push_back(mk(2'b11, 6'b001100, 6'b100010, 32'h0, 3, 0));
        vecs.push_back(mk(2'b11, 6'b001101, 6'b000000, 32'h0, 4, 0));
        vecs.push_back(mk(2'b11, 6'b001110, 6'b000000, 32'h0, 13, 0));
        vecs.push_back(mk(2'b11, 6'b001010, 6'b000000, 32'h0, 5, 0));
        vecs.push_back(mk(2'b11, 6'b001011, 6'b000000, 32'h0, 50, 0));
        vecs.push_back(mk(2'b11, 6'b111111, 6'b000000, 32'h0, 63, 0));
        vecs.push_back(mk(2'b10, 6'b000000, 6'b111111, 32'h0, 63, 0));
        vecs.push_back(mk(2'b10, 6'b000001, 6'b100000, 32'h0, 63, 0));
        vecs.push_back(mk(2'b10, 6'b011100, 6'b000001, 32'h0, 63, 0));

        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;

        // Reset state
        @(negedge Clk);
        check("rst_inready", int'(bus.InReady), 1);
        check("rst_outvalid", int'(bus.OutValid), 0);
        check("rst_aluctl", int'(bus.ALUCtl), 0);
        check("rst_multi", int'(bus.OutMulti), 0);
        check("rst_illegal", int'(bus.Illegal), 0);
        check("rst_hilowe", int'(bus.HiLoWe), 0);
        check("rst_busy", int'(bus.Busy), 0);
        step();

        // First decode: AND, one-cycle latency
        send(mk(2'b10, 6'b000000, 6'b100100, 32'h0, 3, 0), w);
        @(negedge Clk);
        check("first_valid", int'(bus.OutValid), 1);
        check("first_ctl", int'(bus.ALUCtl), 3);
        check("first_multi", int'(bus.OutMulti), 0);
        check("first_illegal", int'(bus.Illegal), 0);
        step();

        // Back-to-back add/sub/or/slt must never wait
        for (int i = 0; i < 4; i++) begin
            send(vecs[i], w);
            check("b2b_wait", w, 0);
        end

        for (int i = 4; i < vecs.size(); i++) send(vecs[i], w);
        repeat (MulCycles + 4) step();
        check("sb_empty", sb.size(), 0);

        // Stall: xori held while OutReady low
        bus.OutReady = 1'b0;
        send(mk(2'b11, 6'b001110, 6'b000000, 32'h0, 13, 0), w);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("stall_valid", int'(bus.OutValid), 1);
            check("stall_ctl", int'(bus.ALUCtl), 13);
            check("stall_inready", int'(bus.InReady), 0);
            step();
        end
        bus.OutReady = 1'b1;
        @(negedge Clk);
        check("handoff_inready", int'(bus.InReady), 1);
        step();
        @(negedge Clk);
        check("handoff_cleared", int'(bus.OutValid), 0);
        step();

        // mult timing: handoff cycle t, then Busy/HiLoWe/InReady per cycle
        send(mk(2'b10, 6'b000000, 6'b011000, 32'h0, 2, 1), w);
        @(negedge Clk);
        check("mul_t_valid", int'(bus.OutValid), 1);
        check("mul_t_multi", int'(bus.OutMulti), 1);
        check("mul_t_inready", int'(bus.InReady), 0);
        check("mul_t_busy", int'(bus.Busy), 0);
        step();
        for (int k = 1; k <= int'(MulCycles); k++) begin
            @(negedge Clk);
            check("mul_busy", int'(bus.Busy), (k < int'(MulCycles)) ? 1 : 0);
            check("mul_hilowe", int'(bus.HiLoWe), (k == int'(MulCycles) - 1) ? 1 : 0);
            check("mul_inready", int'(bus.InReady), (k == int'(MulCycles)) ? 1 : 0);
            check("mul_outvalid", int'(bus.OutValid), 0);
            step();
        end

        // Reset mid-MWAIT aborts without a HiLoWe pulse
        send(mk(2'b10, 6'b011100, 6'b000000, 32'h0, 11, 1), w);
        step();
        @(negedge Clk);
        check("abort_busy_before", int'(bus.Busy), 1);
        step();
        Reset = 1'b1;
        #1;
        check("abort_busy", int'(bus.Busy), 0);
        check("abort_hilowe", int'(bus.HiLoWe), 0);
        check("abort_ctl", int'(bus.ALUCtl), 0);
        check("abort_multi", int'(bus.OutMulti), 0);
        step();
        Reset = 1'b0;
        sb.delete();
        for (int k = 0; k < int'(MulCycles) + 2; k++) begin
            @(negedge Clk);
            check("abort_no_pulse", int'(bus.HiLoWe), 0);
            check("abort_idle", int'(bus.Busy), 0);
            step();
        end

        // Reset drops a stalled pending output
        bus.OutReady = 1'b0;
        send(mk(2'b11, 6'b001101, 6'b000000, 32'h0, 4, 0), w);
        @(negedge Clk);
        check("drop_pending", int'(bus.OutValid), 1);
        Reset = 1'b1;
        #1;
        check("drop_valid", int'(bus.OutValid), 0);
        check("drop_ctl", int'(bus.ALUCtl), 0);
        step();
        Reset        = 1'b0;
        bus.OutReady = 1'b1;
        sb.delete();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
